// File: rtl/kamus_pkg.sv
// Shared types and encodings for the kamus load/store unit.
// Holds the LSU FSM state encoding and the funct3 access-size codes.
package kamus_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane formatting for the LSU: byte enables, store replication,
// misalignment check and load shift/extend.
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_addr_lo,
  output logic        misalign,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_wdata,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  // Reserved funct3 codes can never be legal, so they report as misaligned.
  always_comb begin
    misalign = 1'b1;
    case (chk_funct3)
      LSU_B, LSU_BU: misalign = 1'b0;
      LSU_H, LSU_HU: misalign = chk_addr_lo[0];
      LSU_W:         misalign = (chk_addr_lo != 2'b00);
      default:       misalign = 1'b1;
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    st_data = st_wdata;
    case (funct3)
      LSU_B, LSU_BU: begin
        be      = 4'b0001 << addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        be      = 4'b0011 << addr_lo;
        st_data = {2{st_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = st_wdata;
      end
    endcase
  end

  assign ld_shift = ld_raw >> {addr_lo, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (funct3)
      LSU_B:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      LSU_BU:  ld_data = {24'h000000, ld_shift[7:0]};
      LSU_H:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      LSU_HU:  ld_data = {16'h0000, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencer between EX/MEM and the L1 data-cache port.
// Runs one req/gnt/rvalid transaction at a time and reports the result to WB.
module kamus_lsu_ctrl
  import kamus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        regfile_wr_en_o,
  output logic        lsu_misalign_o,
  output logic        lsu_buserr_o,
  output logic        l1d_req_o,
  input  logic        l1d_gnt_i,
  output logic [31:0] l1d_addr_o,
  output logic        l1d_we_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_wdata_o,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rdata_i,
  output logic [1:0]  lsu_state_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    state_q;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [31:0]   rdata_q;
  logic          wr_en_q;
  logic          misalign_q;
  logic          buserr_q;

  logic          chk_misalign;
  logic [3:0]    fmt_be;
  logic [31:0]   fmt_wdata;
  logic [31:0]   fmt_ldata;
  logic          in_req;

  kamus_lsu_align u_align (
    .chk_funct3  (lsu_funct3_i),
    .chk_addr_lo (lsu_addr_i[1:0]),
    .misalign    (chk_misalign),
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .st_wdata    (wdata_q),
    .ld_raw      (l1d_rdata_i),
    .be          (fmt_be),
    .st_data     (fmt_wdata),
    .ld_data     (fmt_ldata)
  );

  // Bus handshake: l1d_req_o stays high with addr/we/be/wdata stable until a cycle
  // in which l1d_gnt_i is also high; exactly one l1d_rvalid_i per grant, from the next cycle on.
  assign in_req      = (state_q == LSU_REQ);
  assign l1d_req_o   = in_req;
  assign l1d_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign l1d_we_o    = in_req & we_q;
  assign l1d_be_o    = in_req ? fmt_be : 4'b0000;
  assign l1d_wdata_o = in_req ? fmt_wdata : 32'h0;

  assign lsu_busy_o  = ((state_q == LSU_IDLE) & lsu_req_i) |
                       (state_q == LSU_REQ) | (state_q == LSU_WAIT);
  assign lsu_done_o      = done_q;
  assign lsu_rdata_o     = rdata_q;
  assign regfile_wr_en_o = wr_en_q;
  assign lsu_misalign_o  = misalign_q;
  assign lsu_buserr_o    = buserr_q;
  assign lsu_state_o     = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= LSU_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      rdata_q    <= 32'h0;
      wr_en_q    <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rdata_q    <= 32'h0;
      wr_en_q    <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            we_q     <= lsu_we_i;
            funct3_q <= lsu_funct3_i;
            addr_q   <= lsu_addr_i;
            wdata_q  <= lsu_wdata_i;
            if (chk_misalign) begin
              state_q    <= LSU_DONE;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (l1d_gnt_i) begin
            state_q <= LSU_WAIT;
            cnt_q   <= '0;
          end
        end
        LSU_WAIT: begin
          // A response on the final counted cycle still wins over the timeout.
          if (l1d_rvalid_i) begin
            state_q <= LSU_DONE;
            done_q  <= 1'b1;
            if (!we_q) begin
              rdata_q <= fmt_ldata;
              wr_en_q <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= LSU_DONE;
            done_q   <= 1'b1;
            buserr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LSU_DONE: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Directed bench for kamus_lsu_ctrl: store/load formatting, misalignment,
// rvalid timeout and reset while a transaction is in flight.
module tb_kamus_lsu_ctrl;

  localparam int TO = 256;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        regfile_wr_en_o;
  logic        lsu_misalign_o;
  logic        lsu_buserr_o;
  logic        l1d_req_o;
  logic        l1d_gnt_i;
  logic [31:0] l1d_addr_o;
  logic        l1d_we_o;
  logic [3:0]  l1d_be_o;
  logic [31:0] l1d_wdata_o;
  logic        l1d_rvalid_i;
  logic [31:0] l1d_rdata_i;
  logic [1:0]  lsu_state_o;

  int n_assert = 0;
  int n_fail   = 0;

  kamus_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_funct3_i    (lsu_funct3_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .lsu_busy_o      (lsu_busy_o),
    .lsu_done_o      (lsu_done_o),
    .lsu_rdata_o     (lsu_rdata_o),
    .regfile_wr_en_o (regfile_wr_en_o),
    .lsu_misalign_o  (lsu_misalign_o),
    .lsu_buserr_o    (lsu_buserr_o),
    .l1d_req_o       (l1d_req_o),
    .l1d_gnt_i       (l1d_gnt_i),
    .l1d_addr_o      (l1d_addr_o),
    .l1d_we_o        (l1d_we_o),
    .l1d_be_o        (l1d_be_o),
    .l1d_wdata_o     (l1d_wdata_o),
    .l1d_rvalid_i    (l1d_rvalid_i),
    .l1d_rdata_i     (l1d_rdata_i),
    .lsu_state_o     (lsu_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE and step through the accepting edge.
  task automatic accept(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    lsu_req_i    = 1'b1;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wdata;
    #1;
    check("busy_on_accept", {31'b0, lsu_busy_o}, 32'd1);
    step();
    lsu_req_i = 1'b0;
  endtask

  task automatic grant();
    l1d_gnt_i = 1'b1;
    step();
    l1d_gnt_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] raw);
    l1d_rdata_i  = raw;
    l1d_rvalid_i = 1'b1;
    step();
    l1d_rvalid_i = 1'b0;
    l1d_rdata_i  = 32'h0;
  endtask

  initial begin
    int n;
    rst_ni       = 1'b0;
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'b000;
    lsu_addr_i   = 32'h0;
    lsu_wdata_i  = 32'h0;
    l1d_gnt_i    = 1'b0;
    l1d_rvalid_i = 1'b0;
    l1d_rdata_i  = 32'h0;
    step();
    step();

    check("rst_state", {30'b0, lsu_state_o}, 32'd0);
    check("rst_busy", {31'b0, lsu_busy_o}, 32'd0);
    check("rst_done", {31'b0, lsu_done_o}, 32'd0);
    check("rst_req", {31'b0, l1d_req_o}, 32'd0);
    check("rst_be", {28'b0, l1d_be_o}, 32'd0);
    check("rst_rdata", lsu_rdata_o, 32'h0);
    rst_ni = 1'b1;
    step();

    // SW 0x100, grant two cycles after req, rvalid one cycle after grant
    accept(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    check("sw_req", {31'b0, l1d_req_o}, 32'd1);
    check("sw_addr", l1d_addr_o, 32'h0000_0100);
    check("sw_be", {28'b0, l1d_be_o}, 32'h0000_000F);
    check("sw_we", {31'b0, l1d_we_o}, 32'd1);
    check("sw_wdata", l1d_wdata_o, 32'hDEAD_BEEF);
    step();
    check("sw_req_hold", {31'b0, l1d_req_o}, 32'd1);
    check("sw_be_hold", {28'b0, l1d_be_o}, 32'h0000_000F);
    grant();
    check("sw_wait_req", {31'b0, l1d_req_o}, 32'd0);
    check("sw_wait_busy", {31'b0, lsu_busy_o}, 32'd1);
    check("sw_wait_done", {31'b0, lsu_done_o}, 32'd0);
    respond(32'h0);
    check("sw_done", {31'b0, lsu_done_o}, 32'd1);
    check("sw_wr_en", {31'b0, regfile_wr_en_o}, 32'd0);
    check("sw_done_busy", {31'b0, lsu_busy_o}, 32'd0);
    step();
    check("sw_done_pulse", {31'b0, lsu_done_o}, 32'd0);

    // SB 0x103: top lane, byte replicated
    accept(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    check("sb_be", {28'b0, l1d_be_o}, 32'h0000_0008);
    check("sb_wdata", l1d_wdata_o, 32'hA5A5_A5A5);
    check("sb_addr", l1d_addr_o, 32'h0000_0100);
    grant();
    respond(32'h0);
    check("sb_done", {31'b0, lsu_done_o}, 32'd1);
    step();

    // SH 0x102: upper half lanes
    accept(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD);
    check("sh_be", {28'b0, l1d_be_o}, 32'h0000_000C);
    check("sh_wdata", l1d_wdata_o, 32'hABCD_ABCD);
    grant();
    respond(32'h0);
    step();

    // LB 0x201 sign-extends byte 1
    accept(1'b0, 3'b000, 32'h0000_0201, 32'h0);
    check("lb_be", {28'b0, l1d_be_o}, 32'h0000_0002);
    check("lb_addr", l1d_addr_o, 32'h0000_0200);
    check("lb_we", {31'b0, l1d_we_o}, 32'd0);
    grant();
    respond(32'h0000_80FF);
    check("lb_done", {31'b0, lsu_done_o}, 32'd1);
    check("lb_rdata", lsu_rdata_o, 32'hFFFF_FF80);
    check("lb_wr_en", {31'b0, regfile_wr_en_o}, 32'd1);
    step();

    // LHU 0x202 zero-extends upper half; request held through DONE
    accept(1'b0, 3'b101, 32'h0000_0202, 32'h0);
    check("lhu_be", {28'b0, l1d_be_o}, 32'h0000_000C);
    grant();
    respond(32'h8001_0000);
    check("lhu_rdata", lsu_rdata_o, 32'h0000_8001);
    check("lhu_wr_en", {31'b0, regfile_wr_en_o}, 32'd1);
    lsu_req_i    = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'b001;
    lsu_addr_i   = 32'h0000_0202;
    #1;
    check("done_busy_low", {31'b0, lsu_busy_o}, 32'd0);
    step();
    check("no_accept_in_done", {31'b0, l1d_req_o}, 32'd0);
    check("idle_after_done", {30'b0, lsu_state_o}, 32'd0);

    // LH 0x202 (accepted from the held request above) sign-extends
    step();
    lsu_req_i = 1'b0;
    check("lh_req", {31'b0, l1d_req_o}, 32'd1);
    grant();
    respond(32'h8001_0000);
    check("lh_rdata", lsu_rdata_o, 32'hFFFF_8001);
    step();

    // LW 0x102 misaligned: no bus access, done one edge after accept
    accept(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    check("mis_req", {31'b0, l1d_req_o}, 32'd0);
    check("mis_done", {31'b0, lsu_done_o}, 32'd1);
    check("mis_flag", {31'b0, lsu_misalign_o}, 32'd1);
    check("mis_wr_en", {31'b0, regfile_wr_en_o}, 32'd0);
    step();
    check("mis_done_pulse", {31'b0, lsu_done_o}, 32'd0);

    // Reserved funct3 011 at aligned address is flagged too
    accept(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    check("rsv_misalign", {31'b0, lsu_misalign_o}, 32'd1);
    check("rsv_req", {31'b0, l1d_req_o}, 32'd0);
    step();

    // LW with no rvalid: buserr after TO cycles in WAIT
    accept(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    grant();
    n = 0;
    while (lsu_done_o !== 1'b1 && n < TO + 20) begin
      step();
      n++;
    end
    check("to_cycles", n, TO);
    check("to_buserr", {31'b0, lsu_buserr_o}, 32'd1);
    check("to_wr_en", {31'b0, regfile_wr_en_o}, 32'd0);
    check("to_misalign", {31'b0, lsu_misalign_o}, 32'd0);
    step();

    // Reset during WAIT abandons the access; stale rvalid is ignored
    accept(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    grant();
    check("pre_rst_state", {30'b0, lsu_state_o}, 32'd2);
    rst_ni = 1'b0;
    step();
    check("rst_wait_req", {31'b0, l1d_req_o}, 32'd0);
    check("rst_wait_state", {30'b0, lsu_state_o}, 32'd0);
    rst_ni = 1'b1;
    respond(32'h1234_5678);
    check("stale_done", {31'b0, lsu_done_o}, 32'd0);
    step();
    check("stale_done2", {31'b0, lsu_done_o}, 32'd0);
    check("stale_state", {30'b0, lsu_state_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
